// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv_pkg
// Brief    : Shared fetch constants, FSM state type and alignment helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    function automatic logic isWordAligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
//------------------------------------------------------------------------------
// Module   : pc_reg
// Brief    : Program counter with next-PC selection and redirect alignment check.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_reg
    import riscv_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_advance,
    input  logic                     i_redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_target,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    output logic [ADDRESS_WIDTH-1:0] o_pcPlus4,
    output logic                     o_misaligned
);

    localparam logic [ADDRESS_WIDTH-1:0] c_PC_STEP = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_nextPc;
    logic                     w_targetAligned;

    assign w_targetAligned = isWordAligned(i_target[1:0]);

    // A misaligned redirect leaves the PC frozen at the faulting fetch.
    always_comb begin
        w_nextPc = r_pc;
        if (i_redirect) begin
            if (w_targetAligned) begin
                w_nextPc = i_target;
            end
        end else if (i_advance) begin
            w_nextPc = r_pc + c_PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_nextPc;
        end
    end

    assign o_pc         = r_pc;
    assign o_pcPlus4    = r_pc + c_PC_STEP;
    assign o_misaligned = i_redirect & ~w_targetAligned;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module   : fetch_stage
// Brief    : Instruction fetch with IF/ID register and RUN/HALT control FSM.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0]    if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic [ADDRESS_WIDTH-1:0] if_pc_plus4,
    output logic                     if_valid,
    output logic                     halted,
    output logic                     misaligned
);

    localparam logic [DATA_WIDTH-1:0] c_NOP    = DATA_WIDTH'(NOP_INSTR);
    localparam logic [DATA_WIDTH-1:0] c_EBREAK = DATA_WIDTH'(EBREAK_INSTR);

    fetch_state_t             r_state;
    logic [DATA_WIDTH-1:0]    r_ifInstr;
    logic [ADDRESS_WIDTH-1:0] r_ifPc;
    logic [ADDRESS_WIDTH-1:0] r_ifPcPlus4;
    logic                     r_ifValid;
    logic                     r_halted;
    logic                     r_misaligned;

    logic                     w_running;
    logic                     w_redirect;
    logic                     w_capture;
    logic                     w_ebreak;
    logic                     w_advance;
    logic                     w_badTarget;
    logic [ADDRESS_WIDTH-1:0] w_pc;
    logic [ADDRESS_WIDTH-1:0] w_pcPlus4;

    assign w_running  = (r_state == RUN);
    assign w_redirect = w_running & branch_taken;
    assign w_capture  = w_running & ~branch_taken & ~flush & ~stall;
    assign w_ebreak   = w_capture & (instr == c_EBREAK);
    // Flush still lets the PC move on; only stall and EBREAK freeze it.
    assign w_advance  = w_running & ~branch_taken & ~stall & ~w_ebreak;

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_PC      (RESET_PC)
    ) u_pcReg (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (w_advance),
        .i_redirect   (w_redirect),
        .i_target     (branch_target),
        .o_pc         (w_pc),
        .o_pcPlus4    (w_pcPlus4),
        .o_misaligned (w_badTarget)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_ifInstr    <= c_NOP;
            r_ifPc       <= '0;
            r_ifPcPlus4  <= '0;
            r_ifValid    <= 1'b0;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (branch_taken || flush) begin
                        r_ifInstr   <= c_NOP;
                        r_ifPc      <= '0;
                        r_ifPcPlus4 <= '0;
                        r_ifValid   <= 1'b0;
                        if (w_badTarget) begin
                            r_misaligned <= 1'b1;
                            r_halted     <= 1'b1;
                            r_state      <= HALT;
                        end
                    end else if (!stall) begin
                        r_ifInstr   <= instr;
                        r_ifPc      <= w_pc;
                        r_ifPcPlus4 <= w_pcPlus4;
                        r_ifValid   <= 1'b1;
                        if (w_ebreak) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end
                    end
                end
                HALT: begin
                    r_ifValid <= 1'b0;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign PC          = w_pc;
    assign if_instr    = r_ifInstr;
    assign if_pc       = r_ifPc;
    assign if_pc_plus4 = r_ifPcPlus4;
    assign if_valid    = r_ifValid;
    assign halted      = r_halted;
    assign misaligned  = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage with a cycle-level reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] ifInstr;
        logic [15:0] ifPc;
        logic [15:0] ifPcPlus4;
        logic        ifValid;
        logic        halted;
        logic        misaligned;
        logic        checkPc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [31:0] instr;
    logic [15:0] PC;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus4;
    logic        if_valid;
    logic        halted;
    logic        misaligned;

    logic [31:0] mem [0:16383];
    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model state, kept as plain integers.
    int mPc, mIfPc, mIfPcPlus4;
    logic [31:0] mIfInstr;
    bit mValid, mHalted, mMis;

    assign instr = mem[PC[15:2]];

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDRESS_WIDTH (16),
        .DATA_WIDTH    (32),
        .RESET_PC      (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .PC            (PC),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_valid      (if_valid),
        .halted        (halted),
        .misaligned    (misaligned)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic kill();
        mIfInstr = c_NOP;
        mValid   = 1'b0;
    endtask

    // Apply one cycle of inputs and push the model's post-edge expectation.
    task automatic step(input bit r, input bit s, input bit f, input bit b, input int tgt);
        exp_t e;
        logic [31:0] word;
        @(negedge clk);
        rst = r; stall = s; flush = f; branch_taken = b; branch_target = 16'(tgt);
        if (r) begin
            mPc = 0; mIfInstr = c_NOP; mIfPc = 0; mIfPcPlus4 = 0;
            mValid = 0; mHalted = 0; mMis = 0;
        end else if (mHalted) begin
            mValid = 0;
        end else if (b) begin
            if (tgt % 4 == 0) mPc = tgt;
            else begin mMis = 1; mHalted = 1; end
            kill();
        end else if (f) begin
            kill();
            if (!s) mPc = (mPc + 4) % 65536;
        end else if (!s) begin
            word       = mem[mPc / 4];
            mIfInstr   = word;
            mIfPc      = mPc;
            mIfPcPlus4 = (mPc + 4) % 65536;
            mValid     = 1;
            if (word == c_EBREAK) mHalted = 1;
            else mPc = (mPc + 4) % 65536;
        end
        e.pc = 16'(mPc); e.ifInstr = mIfInstr; e.ifPc = 16'(mIfPc);
        e.ifPcPlus4 = 16'(mIfPcPlus4); e.ifValid = mValid; e.halted = mHalted;
        e.misaligned = mMis; e.checkPc = mValid | r;
        sb.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            chk("PC", 32'(PC), 32'(e.pc));
            chk("if_instr", if_instr, e.ifInstr);
            chk("if_valid", 32'(if_valid), 32'(e.ifValid));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("misaligned", 32'(misaligned), 32'(e.misaligned));
            if (e.checkPc) begin
                chk("if_pc", 32'(if_pc), 32'(e.ifPc));
                chk("if_pc_plus4", 32'(if_pc_plus4), 32'(e.ifPcPlus4));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int tgt;
        for (int i = 0; i < 16384; i++) begin
            w = $urandom;
            mem[i] = (w == c_EBREAK) ? (w ^ 32'h1) : w;
        end

        // Reset then free-running fetch.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        // Stall at 0x0010 for two cycles, then resume.
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        // Redirect to 0x0100 while stalled: redirect wins.
        step(0, 1, 0, 1, 32'h100);
        step(0, 0, 0, 0, 0);
        // Flush with and without stall.
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // Wraparound at the top of the address space.
        step(0, 0, 0, 1, 32'hFFFC);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // EBREAK at 0x0008.
        w = mem[2];
        mem[2] = c_EBREAK;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 32'h40);
        step(1, 1, 0, 0, 0);
        mem[2] = w;

        // Misaligned redirect, ignored inputs in HALT, then reset clears flags.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h102);
        for (int i = 0; i < 3; i++) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 32'h200);
        step(1, 0, 0, 1, 32'h103);
        step(0, 0, 0, 0, 0);

        // Randomized traffic with sparse EBREAKs.
        for (int k = 0; k < 200; k++) mem[$urandom_range(0, 16383)] = c_EBREAK;
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            tgt = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 99) < 85) tgt = tgt & 32'hFFFC;
            step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                 tgt);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 16, which sets the byte-address width of the PC.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, which sets the instruction width.
REQ-003 The module SHALL have parameter RESET_PC, default 0, which sets the PC value loaded on reset.
REQ-004 One clock; reset is synchronous and active-high: port clk, input, 1 bit, rising-edge clock.
REQ-005 Port rst SHALL be an input, 1 bit, synchronous and active-high.
REQ-006 Port stall SHALL be an input, 1 bit, that holds the PC and the IF/ID register.
REQ-007 Port flush SHALL be an input, 1 bit, that kills the IF/ID contents.
REQ-008 Port branch_taken SHALL be an input, 1 bit, that redirects the PC to branch_target.
REQ-009 Port branch_target SHALL be an input, ADDRESS_WIDTH bits, giving the redirect byte address.
REQ-010 Port instr SHALL be an input, DATA_WIDTH bits, carrying the assembled word returned combinationally by instruction memory for PC.
REQ-011 Port PC SHALL be an output, ADDRESS_WIDTH bits, giving the byte address driven to instruction memory.
REQ-012 Port if_instr SHALL be an output, DATA_WIDTH bits, giving the registered instruction to decode.
REQ-013 Port if_pc SHALL be an output, ADDRESS_WIDTH bits, giving the PC of if_instr.
REQ-014 Port if_pc_plus4 SHALL be an output, ADDRESS_WIDTH bits, equal to if_pc+4 (used for the JAL/JALR link).
REQ-015 Port if_valid SHALL be an output, 1 bit, that is high when if_instr is a live instruction.
REQ-016 Port halted SHALL be an output, 1 bit, that is high while in state HALT.
REQ-017 Port misaligned SHALL be an output, 1 bit, a sticky flag set when a redirect targets a non-word-aligned address.

Function
REQ-018 The block SHALL implement FSM states RUN and HALT.
REQ-019 In RUN, with no stall or redirect, the block SHALL update PC <= PC+4 on each rising edge, wrapping modulo 2^ADDRESS_WIDTH (e.g. 0xFFFC -> 0x0000).
REQ-020 In RUN with branch_taken=1 and branch_target[1:0]=00, the block SHALL update PC <= branch_target and clear the IF/ID register (if_valid=0, if_instr=NOP 0x00000013) in the same edge.
REQ-021 In RUN with branch_taken=1 and branch_target[1:0]!=00, the block SHALL hold PC, set misaligned=1, clear the IF/ID register, and transition to HALT.
REQ-022 In RUN with no redirect, flush=0 and stall=0, the IF/ID capture SHALL be if_instr<=instr, if_pc<=PC, if_pc_plus4<=PC+4 and if_valid<=1, giving a latency of exactly one cycle from PC to if_*.
REQ-023 With stall=1 and no redirect, the block SHALL hold PC and all if_* outputs unchanged.
REQ-024 With flush=1 and no redirect, the block SHALL clear the IF/ID register (if_valid=0, if_instr=NOP); PC SHALL advance unless stall=1, in which case PC holds.
REQ-025 Priority SHALL be rst > branch_taken > flush > stall.
REQ-026 When branch_taken and stall are asserted together, the redirect SHALL win.
REQ-027 When RUN captures instr equal to EBREAK (0x00100073), the block SHALL register it with if_valid=1, hold PC, and transition to HALT on the same edge.
REQ-028 In HALT, the block SHALL hold PC; if_valid SHALL go to 0 on the first HALT edge and remain 0.
REQ-029 In HALT, stall, flush and branch_taken SHALL be ignored; the only exit from HALT is rst.
REQ-030 halted SHALL be 1 exactly while in state HALT.
REQ-031 misaligned SHALL be cleared only by rst.

Reset
REQ-032 On a rising edge with rst=1, the block SHALL set PC=RESET_PC, if_instr=NOP, if_pc=0, if_pc_plus4=0, if_valid=0, state=RUN, halted=0 and misaligned=0.
REQ-033 Reset SHALL override all other inputs in every state, including mid-stall and HALT.
REQ-034 On the first edge after rst deasserts, the block SHALL capture the instruction at RESET_PC.

Structure
REQ-035 The constants NOP_INSTR and EBREAK_INSTR and the state enum fetch_state_t SHALL reside in shared package riscv_pkg.
REQ-036 The PC register with next-PC mux and alignment check SHALL be sub-module pc_reg; the IF/ID register and FSM SHALL remain in fetch_stage.
REQ-037 The block SHALL contain no memory; instruction memory is instantiated alongside it, with PC feeding its address.

Verification
REQ-038 Scenario: reset, then 4 free-running cycles -> PC = 0,4,8,12,16; if_pc lags PC by one cycle; if_valid=1 from the 2nd cycle.
REQ-039 Scenario: at PC=0x0010, assert stall for 2 cycles -> PC stays 0x0010 and if_* unchanged; PC resumes with 0x0014.
REQ-040 Scenario: at PC=0x0020, branch_taken with target 0x0100 while stall=1 -> next PC=0x0100, if_valid=0, if_instr=0x00000013.
REQ-041 Scenario: branch_taken with target 0x0102 -> misaligned=1, halted=1, PC frozen; rst then clears both flags and PC=RESET_PC.
REQ-042 Scenario: instr=0x00100073 at PC=0x0008 -> if_instr=0x00100073 with if_valid=1, halted=1, PC stays 0x0008, then if_valid=0.
REQ-043 Scenario: ADDRESS_WIDTH=16 with PC=0xFFFC -> next PC=0x0000 and if_pc_plus4=0x0000.
